// File: rtl/vga_pkg.sv
// Shared types and helpers for the per-frame video signature engine.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2
    } sig_state_t;

    localparam int CHK_W       = 32;
    localparam int MAX_COLOR_W = 10;

    // Pack one pixel as R<<(2*cw) | G<<cw | B, zero-extended to the checksum width.
    // Channels arrive zero-extended to MAX_COLOR_W so one function serves every COLOR_W.
    function automatic logic [CHK_W-1:0] pix_word(
        input logic [MAX_COLOR_W-1:0] r,
        input logic [MAX_COLOR_W-1:0] g,
        input logic [MAX_COLOR_W-1:0] b,
        input int unsigned            cw
    );
        logic [CHK_W-1:0] rr;
        logic [CHK_W-1:0] gg;
        logic [CHK_W-1:0] bb;
        rr = CHK_W'(r);
        gg = CHK_W'(g);
        bb = CHK_W'(b);
        return (rr << (2 * cw)) | (gg << cw) | bb;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to align sync strobes with late pixel data.
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_d
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign data_d = data;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] pipe;

            // Shift the input one stage per clock; reset flushes every stage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= data;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign data_d = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_frame_signature.sv
// Per-frame signature engine: aligns sync strobes to the RGB pipeline, sums
// pixel words, counts pixels and lines, and flags geometry errors per frame.
module vga_frame_signature
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int COLOR_W  = 8,
    parameter int DATA_LAT = 2,
    parameter int VS_POL   = 0,
    localparam int PIX_W   = $clog2(H_ACTIVE * V_ACTIVE + 1),
    localparam int LINE_W  = $clog2(V_ACTIVE + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active_video,
    input  logic               vsync,
    input  logic [COLOR_W-1:0] R,
    input  logic [COLOR_W-1:0] G,
    input  logic [COLOR_W-1:0] B,
    input  logic               arm,
    input  logic               continuous,
    output logic               busy,
    output logic               done,
    output logic [CHK_W-1:0]   checksum,
    output logic [PIX_W-1:0]   pix_count,
    output logic [LINE_W-1:0]  line_count,
    output logic               frame_err,
    output logic [15:0]        frame_count
);

    localparam int   COL_W  = $clog2(H_ACTIVE + 1);
    localparam logic VS_ACT = (VS_POL != 0);

    sig_state_t        state;
    logic [1:0]        strobes_d;
    logic              av_d;
    logic              vs_d;
    logic              av_prev;
    logic              vs_prev;
    logic              sof;
    logic              eol;

    logic [CHK_W-1:0]  acc;
    logic [PIX_W-1:0]  pix;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] row;
    logic              line_err;

    logic [CHK_W-1:0]  word;
    logic [CHK_W-1:0]  acc_start;
    logic [PIX_W-1:0]  pix_inc;
    logic [PIX_W-1:0]  pix_start;
    logic [COL_W-1:0]  col_inc;
    logic [COL_W-1:0]  col_start;
    logic [LINE_W-1:0] row_next;
    logic              line_err_next;

    vga_delay_line #(
        .WIDTH (2),
        .DEPTH (DATA_LAT)
    ) u_align (
        .clk    (clk),
        .reset  (reset),
        .data   ({active_video, vsync}),
        .data_d (strobes_d)
    );

    assign av_d = strobes_d[1];
    assign vs_d = strobes_d[0];
    assign sof  = (vs_d == VS_ACT) && (vs_prev != VS_ACT);
    assign eol  = av_prev && !av_d;
    assign busy = (state != IDLE);

    // Next-value helpers: saturating counters, end-of-line bookkeeping, and the
    // accumulator seed used when a frame boundary coincides with a live pixel.
    always_comb begin
        word          = pix_word(MAX_COLOR_W'(R), MAX_COLOR_W'(G), MAX_COLOR_W'(B), COLOR_W);
        pix_inc       = (pix == '1) ? pix : pix + 1'b1;
        col_inc       = (col == '1) ? col : col + 1'b1;
        row_next      = row;
        line_err_next = line_err;
        if (eol) begin
            row_next      = (row == '1) ? row : row + 1'b1;
            line_err_next = line_err || (col != COL_W'(H_ACTIVE));
        end
        acc_start = av_d ? word : '0;
        pix_start = av_d ? PIX_W'(1) : '0;
        col_start = av_d ? COL_W'(1) : '0;
    end

    // Edge-detect history; vsync history starts inactive so reset release is not a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            av_prev <= 1'b0;
            vs_prev <= ~VS_ACT;
        end else begin
            av_prev <= av_d;
            vs_prev <= vs_d;
        end
    end

    // Capture FSM with accumulators and latched per-frame results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            pix         <= '0;
            col         <= '0;
            row         <= '0;
            line_err    <= 1'b0;
            done        <= 1'b0;
            checksum    <= '0;
            pix_count   <= '0;
            line_count  <= '0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (sof) begin
                        acc      <= acc_start;
                        pix      <= pix_start;
                        col      <= col_start;
                        row      <= '0;
                        line_err <= 1'b0;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (sof) begin
                        // Results include any end-of-line landing on this boundary;
                        // a pixel on this cycle seeds the next frame instead.
                        checksum    <= acc;
                        pix_count   <= pix;
                        line_count  <= row_next;
                        frame_err   <= line_err_next || (row_next != LINE_W'(V_ACTIVE));
                        done        <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        acc         <= acc_start;
                        pix         <= pix_start;
                        col         <= col_start;
                        row         <= '0;
                        line_err    <= 1'b0;
                        state       <= continuous ? CAPTURE : IDLE;
                    end else begin
                        if (av_d) begin
                            acc <= acc + word;
                            pix <= pix_inc;
                        end
                        if (eol) begin
                            col      <= '0;
                            row      <= row_next;
                            line_err <= line_err_next;
                        end else if (av_d) begin
                            col <= col_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_signature.sv
// Randomized frame-level bench: a tiny timing generator drives frames, a
// per-frame model sums pixels and checks geometry, and a done monitor compares.
module tb_vga_frame_signature;

    localparam int H      = 4;
    localparam int V      = 3;
    localparam int LAT    = 2;
    localparam int CW     = 8;
    localparam int PIX_W  = $clog2(H * V + 1);
    localparam int LINE_W = $clog2(V + 1);
    localparam logic [23:0] PORCH = 24'hFFFFFF;

    logic              clk = 1'b0;
    logic              reset;
    logic              active_video;
    logic              vsync;
    logic [CW-1:0]     R, G, B;
    logic              arm;
    logic              continuous;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;
    logic [PIX_W-1:0]  pix_count;
    logic [LINE_W-1:0] line_count;
    logic              frame_err;
    logic [15:0]       frame_count;

    vga_frame_signature #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .COLOR_W  (CW),
        .DATA_LAT (LAT),
        .VS_POL   (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .active_video (active_video),
        .vsync        (vsync),
        .R            (R),
        .G            (G),
        .B            (B),
        .arm          (arm),
        .continuous   (continuous),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum),
        .pix_count    (pix_count),
        .line_count   (line_count),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] chk;
        int          pix;
        int          lines;
        bit          err;
        int          fc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          done_exp = 0;
    int          model_fc = 0;
    longint      cyc = 0;
    longint      vs_cyc = 0;
    bit          prev_done = 1'b0;
    logic [23:0] hist [LAT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every done pulse must match the oldest outstanding frame prediction.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check("done_pulse_width", {31'd0, prev_done}, 32'd0);
            check("done_latency", 32'(cyc - vs_cyc), 32'(LAT + 1));
            check("exp_pending", exp_q.size(), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("checksum", checksum, e.chk);
                check("pix_count", 32'(pix_count), e.pix);
                check("line_count", 32'(line_count), e.lines);
                check("frame_err", {31'd0, frame_err}, {31'd0, e.err});
                check("frame_count", 32'(frame_count), e.fc);
            end
        end
        prev_done = done;
    end

    // One pixel-clock cycle: strobes now, RGB from LAT cycles ago.
    task automatic tick(input bit av, input bit vs, input logic [23:0] px);
        @(posedge clk);
        #1;
        active_video = av;
        vsync        = vs;
        {R, G, B}    = hist[LAT-1];
        for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = px;
    endtask

    // Drive one frame (vsync pulse then lines). mode: 0 const 1/2/3, 1 index, 2 random.
    // drop_line: after that line, release continuous and arm. rst_line: reset mid-line, abort.
    task automatic drive_frame(input int lens[4], input int nl, input int mode, input bit cap,
                               input int drop_line, input int rst_line);
        logic [31:0] sum;
        logic [23:0] px;
        int          npix;
        int          idx;
        int          lines;
        bit          err;
        sum = 0; npix = 0; idx = 0; lines = 0; err = 0;
        tick(0, 0, PORCH);
        vs_cyc = cyc;
        tick(0, 0, PORCH);
        repeat (2) tick(0, 1, PORCH);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < lens[l]; p++) begin
                if (rst_line == l && p == 1) begin
                    reset = 1'b1;
                    repeat (2) tick(0, 1, PORCH);
                    reset    = 1'b0;
                    model_fc = 0;
                    exp_q.delete();
                    return;
                end
                case (mode)
                    0:       px = 24'h010203;
                    1:       px = 24'(idx);
                    default: px = 24'($urandom);
                endcase
                tick(1, 1, px);
                sum = sum + px[23:16] * 65536 + px[15:8] * 256 + px[7:0];
                npix++;
                idx++;
            end
            if (lens[l] > 0) lines++;
            if (lens[l] != H) err = 1;
            repeat (3) tick(0, 1, PORCH);
            if (drop_line == l) begin
                continuous = 1'b0;
                arm        = 1'b0;
            end
        end
        if (lines != V) err = 1;
        repeat (2) tick(0, 1, PORCH);
        if (cap) begin
            exp_t e;
            model_fc = (model_fc + 1) & 16'hFFFF;
            e.chk = sum; e.pix = npix; e.lines = lines; e.err = err; e.fc = model_fc;
            exp_q.push_back(e);
            done_exp++;
        end
    endtask

    task automatic close_frame();
        drive_frame('{0, 0, 0, 0}, 0, 0, 0, -1, -1);
        repeat (3) tick(0, 1, PORCH);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick(0, 1, PORCH);
        arm = 1'b0;
        @(negedge clk);
        check("busy_after_arm", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; continuous = 1'b0;
        active_video = 1'b0; vsync = 1'b1; R = '0; G = '0; B = '0;
        for (int i = 0; i < LAT; i++) hist[i] = PORCH;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_checksum", checksum, 32'd0);
        check("rst_pix", 32'(pix_count), 32'd0);
        check("rst_line", 32'(line_count), 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (4) tick(0, 1, PORCH);

        // Single shot with constant pixel.
        arm_pulse();
        drive_frame('{4, 4, 4, 0}, 3, 0, 1, -1, -1);
        close_frame();
        @(negedge clk);
        check("ss_checksum", checksum, 32'h000C1824);
        check("ss_pix", 32'(pix_count), 32'd12);
        check("ss_busy", {31'd0, busy}, 32'd0);
        check("ss_done_cnt", done_cnt, done_exp);

        // Continuous, index pixels; continuous dropped mid third frame.
        continuous = 1'b1;
        arm_pulse();
        for (int f = 0; f < 3; f++) begin
            drive_frame('{4, 4, 4, 0}, 3, 1, 1, (f == 2) ? 1 : -1, -1);
            @(negedge clk);
            check("cont_busy", {31'd0, busy}, 32'd1);
        end
        close_frame();
        @(negedge clk);
        check("cont_checksum", checksum, 32'd66);
        check("cont_busy_end", {31'd0, busy}, 32'd0);
        check("cont_done_cnt", done_cnt, done_exp);

        // Short line, then a clean random frame.
        arm_pulse();
        drive_frame('{4, 3, 4, 0}, 3, 2, 1, -1, -1);
        close_frame();
        @(negedge clk);
        check("short_err", {31'd0, frame_err}, 32'd1);
        check("short_pix", 32'(pix_count), 32'd11);
        arm_pulse();
        drive_frame('{4, 4, 4, 0}, 3, 2, 1, -1, -1);
        close_frame();
        @(negedge clk);
        check("clean_err", {31'd0, frame_err}, 32'd0);

        // Arm held through capture; both controls dropped mid second frame.
        continuous = 1'b1;
        arm        = 1'b1;
        drive_frame('{4, 4, 4, 0}, 3, 2, 1, -1, -1);
        drive_frame('{4, 4, 4, 0}, 3, 2, 1, 1, -1);
        close_frame();
        repeat (8) tick(0, 1, PORCH);
        @(negedge clk);
        check("held_arm_busy", {31'd0, busy}, 32'd0);
        check("held_arm_done_cnt", done_cnt, done_exp);

        // Mid-frame reset: everything clears, no done, then a fresh capture.
        arm_pulse();
        drive_frame('{4, 4, 4, 0}, 3, 2, 1, -1, 1);
        repeat (8) tick(0, 1, PORCH);
        @(negedge clk);
        check("mrst_checksum", checksum, 32'd0);
        check("mrst_pix", 32'(pix_count), 32'd0);
        check("mrst_fc", 32'(frame_count), 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done_cnt", done_cnt, done_exp);
        arm_pulse();
        drive_frame('{4, 4, 4, 0}, 3, 2, 1, -1, -1);
        close_frame();
        @(negedge clk);
        check("post_rst_fc", 32'(frame_count), 32'd1);
        check("final_done_cnt", done_cnt, done_exp);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
